// File: rtl/nios_fprint_cpu_jtag_debug_host_seq_if.sv
// Host-side command/response interface of the virtual-JTAG debug host sequencer.
//   cmd_valid/cmd_ready/cmd_ir/cmd_data : one scan request (IR value + shift data)
//   rsp_valid/rsp_ready/rsp_data        : captured tdo bits of the completed scan
// master = requester side, slave = sequencer side.
interface nios_fprint_cpu_jtag_debug_host_seq_if #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [SR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [SR_WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/nios_fprint_cpu_jtag_debug_host_seq.sv
// Initiator-side sequencer for the CPU JTAG debug module's virtual-JTAG port.
// Each accepted command becomes one full scan: UIR, CDR, SDR x SR_WIDTH, UDR,
// RTI x RTI_TCKS, after which the captured tdo bits are offered as a response.
// Ports:
//   clk, reset_n        : system clock, asynchronous active-low reset
//   host (slave)        : command / response handshake interface
//   busy                : high whenever the sequencer is not idle
//   vji_tck/tdi/tdo     : generated tck, serial data out, serial data in
//   vji_ir_in           : virtual IR held for the whole scan
//   vji_uir..vji_rti    : virtual TAP state indicators
module nios_fprint_cpu_jtag_debug_host_seq #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_HALF = 2,
  parameter int RTI_TCKS = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  nios_fprint_cpu_jtag_debug_host_seq_if.slave host,
  output logic                busy,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int PW = $clog2(2*TCK_HALF + 1);
  localparam int CW = $clog2(SR_WIDTH + 256);
  localparam logic [PW-1:0] PH_RISE = PW'(TCK_HALF - 1);    // edge that raises tck
  localparam logic [PW-1:0] PH_LAST = PW'(2*TCK_HALF - 1);  // edge that ends the period

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, RSP} state_e;

  state_e              state_q;
  logic [PW-1:0]       ph_q;
  logic [CW-1:0]       cnt_q;
  logic [SR_WIDTH-1:0] shift_q;
  logic [SR_WIDTH-1:0] rsp_data_q;
  logic [IR_WIDTH-1:0] ir_q;
  logic tck_q, tdi_q, uir_q, cdr_q, sdr_q, udr_q, rti_q;
  logic rsp_valid_q, cmd_ready_q, busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ph_q        <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      rsp_data_q  <= '0;
      ir_q        <= '0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Command fields are captured only here; the scan never looks at them again.
          if (host.cmd_valid) begin
            state_q     <= UIR;
            ir_q        <= host.cmd_ir;
            shift_q     <= host.cmd_data;
            uir_q       <= 1'b1;
            rti_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            ph_q        <= '0;
            cnt_q       <= '0;
          end
        end

        RSP: begin
          if (host.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          // Rise edge: tck goes high and, while shifting, tdo is captured MSB-in.
          if (ph_q == PH_RISE) begin
            tck_q <= 1'b1;
            if (state_q == SDR) begin
              shift_q <= {vji_tdo, shift_q[SR_WIDTH-1:1]};
              cnt_q   <= cnt_q + CW'(1);
            end
          end

          // Period end: tck falls and every state output updates together,
          // so the new values are visible from the first clk of the next period.
          if (ph_q == PH_LAST) begin
            ph_q  <= '0;
            tck_q <= 1'b0;
            case (state_q)
              UIR: begin
                uir_q   <= 1'b0;
                cdr_q   <= 1'b1;
                state_q <= CDR;
              end
              CDR: begin
                cdr_q   <= 1'b0;
                sdr_q   <= 1'b1;
                tdi_q   <= shift_q[0];
                cnt_q   <= '0;
                state_q <= SDR;
              end
              SDR: begin
                if (cnt_q == CW'(SR_WIDTH)) begin
                  sdr_q   <= 1'b0;
                  udr_q   <= 1'b1;
                  tdi_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= UDR;
                end else begin
                  tdi_q <= shift_q[0];
                end
              end
              UDR: begin
                udr_q   <= 1'b0;
                rti_q   <= 1'b1;
                cnt_q   <= '0;
                state_q <= RTI;
              end
              RTI: begin
                if (cnt_q == CW'(RTI_TCKS - 1)) begin
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= shift_q;
                  cnt_q       <= '0;
                  state_q     <= RSP;
                end else begin
                  cnt_q <= cnt_q + CW'(1);
                end
              end
              default: state_q <= IDLE;
            endcase
          end else begin
            ph_q <= ph_q + PW'(1);
          end
        end
      endcase
    end
  end

  assign host.cmd_ready = cmd_ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;
  assign busy           = busy_q;
  assign vji_tck        = tck_q;
  assign vji_tdi        = tdi_q;
  assign vji_ir_in      = ir_q;
  assign vji_uir        = uir_q;
  assign vji_cdr        = cdr_q;
  assign vji_sdr        = sdr_q;
  assign vji_udr        = udr_q;
  assign vji_rti        = rti_q;

endmodule

// File: tb/tb_nios_fprint_cpu_jtag_debug_host_seq.sv
module tb_nios_fprint_cpu_jtag_debug_host_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- DUT A: default timing ----------------
  nios_fprint_cpu_jtag_debug_host_seq_if #(.SR_WIDTH(38), .IR_WIDTH(2)) if_a ();
  logic       busy_a, tck_a, tdi_a, tdo_a, uir_a, cdr_a, sdr_a, udr_a, rti_a;
  logic [1:0] ir_a;
  logic       loop_a = 1'b1;
  logic       tdo_drv = 1'b0;
  assign tdo_a = loop_a ? tdi_a : tdo_drv;

  nios_fprint_cpu_jtag_debug_host_seq #(
    .SR_WIDTH(38), .IR_WIDTH(2), .TCK_HALF(2), .RTI_TCKS(2)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .host(if_a), .busy(busy_a),
    .vji_tck(tck_a), .vji_tdi(tdi_a), .vji_tdo(tdo_a), .vji_ir_in(ir_a),
    .vji_uir(uir_a), .vji_cdr(cdr_a), .vji_sdr(sdr_a), .vji_udr(udr_a), .vji_rti(rti_a)
  );

  // ---------------- DUT B: fastest timing, loopback ----------------
  nios_fprint_cpu_jtag_debug_host_seq_if #(.SR_WIDTH(38), .IR_WIDTH(2)) if_b ();
  logic       busy_b, tck_b, tdi_b, uir_b, cdr_b, sdr_b, udr_b, rti_b;
  logic [1:0] ir_b;

  nios_fprint_cpu_jtag_debug_host_seq #(
    .SR_WIDTH(38), .IR_WIDTH(2), .TCK_HALF(1), .RTI_TCKS(1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .host(if_b), .busy(busy_b),
    .vji_tck(tck_b), .vji_tdi(tdi_b), .vji_tdo(tdi_b), .vji_ir_in(ir_b),
    .vji_uir(uir_b), .vji_cdr(cdr_b), .vji_sdr(sdr_b), .vji_udr(udr_b), .vji_rti(rti_b)
  );

  // Results of the most recent scan
  int          r_off, r_rises, r_uir_first, r_uir_cnt, r_cdr_first, r_cdr_cnt, r_notoggle;
  logic [37:0] r_tdi;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake happens in the current cycle (offset 0); runs until rsp_valid.
  // mode 0: loopback, 1: tdo=1 in first SDR period, 2: tdo=1 in last SDR period.
  task automatic scan_a(input logic [37:0] d, input logic [1:0] ir, input int mode);
    logic prev_tck;
    if_a.cmd_data  = d;
    if_a.cmd_ir    = ir;
    if_a.cmd_valid = 1'b1;
    loop_a  = (mode == 0);
    tdo_drv = 1'b0;
    r_off = 0; r_rises = 0; r_uir_first = 0; r_uir_cnt = 0; r_cdr_first = 0; r_cdr_cnt = 0;
    r_tdi = '0;
    prev_tck = 1'b0;
    for (int o = 1; o <= 400; o++) begin
      step();
      if (o == 1) begin
        if_a.cmd_valid = 1'b0;
        if_a.cmd_data  = ~d;
        if_a.cmd_ir    = ~ir;
      end
      tdo_drv = ((mode == 1) && (o >= 9) && (o <= 12)) ||
                ((mode == 2) && (o >= 157) && (o <= 160));
      if (uir_a) begin
        if (r_uir_first == 0) r_uir_first = o;
        r_uir_cnt++;
      end
      if (cdr_a) begin
        if (r_cdr_first == 0) r_cdr_first = o;
        r_cdr_cnt++;
      end
      if (tck_a && !prev_tck && sdr_a) begin
        if (r_rises < 38) r_tdi[r_rises] = tdi_a;
        r_rises++;
      end
      prev_tck = tck_a;
      if (if_a.rsp_valid) begin
        r_off = o;
        break;
      end
    end
    tdo_drv = 1'b0;
  endtask

  task automatic scan_b(input logic [37:0] d, input logic [1:0] ir);
    logic prev_tck;
    if_b.cmd_data  = d;
    if_b.cmd_ir    = ir;
    if_b.cmd_valid = 1'b1;
    r_off = 0; r_rises = 0; r_notoggle = 0;
    prev_tck = 1'b0;
    for (int o = 1; o <= 200; o++) begin
      step();
      if (o == 1) begin
        if_b.cmd_valid = 1'b0;
        if_b.cmd_data  = ~d;
      end
      if (o >= 2 && !if_b.rsp_valid && (tck_b == prev_tck)) r_notoggle++;
      if (tck_b && !prev_tck && sdr_b) r_rises++;
      prev_tck = tck_b;
      if (if_b.rsp_valid) begin
        r_off = o;
        break;
      end
    end
  endtask

  initial begin
    logic [37:0] held;
    int          unstable;
    int          spurious;

    if_a.cmd_valid = 1'b0; if_a.cmd_ir = '0; if_a.cmd_data = '0; if_a.rsp_ready = 1'b0;
    if_b.cmd_valid = 1'b0; if_b.cmd_ir = '0; if_b.cmd_data = '0; if_b.rsp_ready = 1'b0;

    // Reset values
    step(); step();
    chk("rst_tck",       tck_a, 0);
    chk("rst_rti",       rti_a, 1);
    chk("rst_strobes",   {uir_a, cdr_a, sdr_a, udr_a, tdi_a}, 0);
    chk("rst_cmd_ready", if_a.cmd_ready, 1);
    chk("rst_busy",      busy_a, 0);
    chk("rst_rsp",       {if_a.rsp_valid, if_a.rsp_data}, 0);
    chk("rst_ir",        ir_a, 0);
    reset_n = 1'b1;
    step();

    // Loopback scan; command fields are altered right after the handshake
    scan_a(38'h2A_5A5A_5A5A, 2'b10, 0);
    chk("lb_uir_first",  r_uir_first, 1);
    chk("lb_uir_cnt",    r_uir_cnt, 4);
    chk("lb_cdr_first",  r_cdr_first, 5);
    chk("lb_cdr_cnt",    r_cdr_cnt, 4);
    chk("lb_sdr_rises",  r_rises, 38);
    chk("lb_rsp_latency", r_off, 173);
    chk("lb_rsp_data",   if_a.rsp_data, 38'h2A_5A5A_5A5A);
    chk("lb_ir_in",      ir_a, 2'b10);
    chk("lb_tdi_stream", r_tdi, 38'h2A_5A5A_5A5A);
    chk("lb_rsp_strobes", {uir_a, cdr_a, sdr_a, udr_a, rti_a}, 5'b00001);

    // Backpressure for 20 cycles with a new command pending
    held = if_a.rsp_data;
    unstable = 0;
    if_a.cmd_valid = 1'b1;
    if_a.cmd_data  = 38'h3F_FFFF_FFFF;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!if_a.rsp_valid || (if_a.rsp_data !== held) || tck_a || if_a.cmd_ready || !busy_a)
        unstable++;
    end
    chk("bp_stable", unstable, 0);
    if_a.rsp_ready = 1'b1;
    step();
    if_a.rsp_ready = 1'b0;
    chk("bp_release_idle", {if_a.rsp_valid, busy_a, if_a.cmd_ready}, 3'b001);
    chk("bp_ir_kept",      ir_a, 2'b10);

    // Pending command accepted in this cycle: capture of tdo in first SDR period
    scan_a(38'h00_0000_0000, 2'b01, 1);
    chk("first_hot_rsp",     if_a.rsp_data, 38'h1);
    chk("first_hot_latency", r_off, 173);
    chk("first_hot_ir",      ir_a, 2'b01);
    if_a.rsp_ready = 1'b1;
    step();
    if_a.rsp_ready = 1'b0;

    // Capture of tdo in last SDR period
    scan_a(38'h15_5555_5555, 2'b11, 2);
    chk("last_hot_rsp", if_a.rsp_data, 38'h20_0000_0000);
    if_a.rsp_ready = 1'b1;
    step();
    if_a.rsp_ready = 1'b0;

    // Reset in the middle of SDR while tck is high
    loop_a = 1'b1;
    if_a.cmd_data  = 38'h0F_0F0F_0F0F;
    if_a.cmd_ir    = 2'b11;
    if_a.cmd_valid = 1'b1;
    step();
    if_a.cmd_valid = 1'b0;
    for (int i = 2; i <= 31; i++) step();
    chk("mid_pre_tck_sdr", {tck_a, sdr_a}, 2'b11);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_tck",   tck_a, 0);
    chk("mid_rst_sdr",   sdr_a, 0);
    chk("mid_rst_rti",   rti_a, 1);
    chk("mid_rst_idle",  {busy_a, if_a.cmd_ready}, 2'b01);
    chk("mid_rst_ir",    ir_a, 0);
    step();
    reset_n = 1'b1;
    if_a.rsp_ready = 1'b1;
    spurious = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (if_a.rsp_valid || busy_a) spurious++;
    end
    if_a.rsp_ready = 1'b0;
    chk("mid_rst_no_rsp", spurious, 0);

    // Fast instance: TCK_HALF=1, RTI_TCKS=1, loopback
    scan_b(38'h15_A5A5_C3C3, 2'b01);
    chk("fast_latency",  r_off, 85);
    chk("fast_toggle",   r_notoggle, 0);
    chk("fast_rises",    r_rises, 38);
    chk("fast_rsp_data", if_b.rsp_data, 38'h15_A5A5_C3C3);
    chk("fast_ir",       ir_b, 2'b01);
    if_b.rsp_ready = 1'b1;
    step();
    if_b.rsp_ready = 1'b0;
    chk("fast_idle", {if_b.rsp_valid, busy_b, if_b.cmd_ready}, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
